// File: rtl/router_output_arbiter.sv
// Per-output round-robin arbiter for the 16-port serial router.
// Holds one grant per frame; releases on done or hang timeout.
module router_output_arbiter #(
   parameter int NPORTS  = 16,
   parameter int ID_W    = 4,
   parameter int TIMEOUT = 1024,
   parameter int TMO_W   = 11
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [NPORTS-1:0] req,
   input  logic [NPORTS-1:0] done,
   output logic [NPORTS-1:0] grant,
   output logic [ID_W-1:0]   grant_id,
   output logic              grant_valid,
   output logic              timeout_err,
   output logic [15:0]       pkt_count
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t            state_q;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [TMO_W-1:0]  timer_q;
   logic [NPORTS-1:0] grant_q;
   logic              valid_q;
   logic              terr_q;
   logic [15:0]       cnt_q;

   logic              hit_d;
   logic [ID_W-1:0]   sel_d;
   logic [ID_W-1:0]   idx_d;
   logic [ID_W-1:0]   ptr_d;
   logic              done_hit;
   logic              tmo_hit;

   localparam logic [NPORTS-1:0] ONE = {{(NPORTS-1){1'b0}}, 1'b1};

   // First requester at or after ptr, wrapping at NPORTS-1.
   always_comb begin
      hit_d = 1'b0;
      sel_d = '0;
      idx_d = '0;
      for (int i = 0; i < NPORTS; i++) begin
         idx_d = ID_W'((int'(ptr_q) + i) % NPORTS);
         if (!hit_d && req[idx_d]) begin
            hit_d = 1'b1;
            sel_d = idx_d;
         end
      end
   end

   assign done_hit = done[id_q];
   assign tmo_hit  = (timer_q == TMO_W'(TIMEOUT - 1));
   assign ptr_d    = (id_q == ID_W'(NPORTS - 1)) ? '0 : id_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         timer_q <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         terr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         terr_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (enable && hit_d) begin
                  grant_q <= ONE << sel_d;
                  id_q    <= sel_d;
                  valid_q <= 1'b1;
                  timer_q <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               timer_q <= timer_q + 1'b1;
               if (done_hit || tmo_hit) begin
                  grant_q <= '0;
                  id_q    <= '0;
                  valid_q <= 1'b0;
                  ptr_q   <= ptr_d;
                  state_q <= GAP;
                  // done on the final timer cycle still counts as a frame
                  if (done_hit) begin
                     if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
                  end else begin
                     terr_q <= 1'b1;
                  end
               end
            end
            GAP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_id    = id_q;
   assign grant_valid = valid_q;
   assign timeout_err = terr_q;
   assign pkt_count   = cnt_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Scoreboard bench for router_output_arbiter.
// Expected grant ids are queued at stimulus time, popped on grant rise.
module tb_router_output_arbiter;

   localparam int NPORTS  = 16;
   localparam int ID_W    = 4;
   localparam int TIMEOUT = 1024;
   localparam int TMO_W   = 11;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] done;
   logic [NPORTS-1:0] grant;
   logic [ID_W-1:0]   grant_id;
   logic              grant_valid;
   logic              timeout_err;
   logic [15:0]       pkt_count;

   int   n_chk = 0;
   int   n_err = 0;
   int   exp_q[$];
   int   exp_cnt = 0;
   logic prev_v = 1'b0;

   router_output_arbiter #(
      .NPORTS(NPORTS), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .req(req), .done(done), .grant(grant),
      .grant_id(grant_id), .grant_valid(grant_valid),
      .timeout_err(timeout_err), .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: each new grant must match the oldest queued id.
   always @(negedge clock) begin
      if (grant_valid && !prev_v) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 32'(grant_id), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("gid", 32'(grant_id), 32'(e));
            chk("gvec", 32'(grant), 32'(1) << e);
         end
      end
      if (!grant_valid) chk("idle_z", {16'(grant), 16'(grant_id)}, 32'h0);
      prev_v <= grant_valid;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic grant_wait(input int max);
      int k;
      k = 0;
      while (!grant_valid && k < max) begin
         @(negedge clock);
         k++;
      end
      if (!grant_valid) chk("grant_to", 32'(0), 32'(1));
   endtask

   task automatic finish_frame(input int id);
      done = 16'(1) << id;
      @(negedge clock);
      done = '0;
      exp_cnt++;
      chk("rel_v", 32'(grant_valid), 32'(0));
      chk("rel_terr", 32'(timeout_err), 32'(0));
      chk("pkt", 32'(pkt_count), 32'(exp_cnt));
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      req    = '0;
      done   = '0;
      // reset / idle
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk("rst_g", 32'(grant), 32'(0));
         chk("rst_v", 32'(grant_valid), 32'(0));
         chk("rst_pkt", 32'(pkt_count), 32'(0));
         chk("rst_terr", 32'(timeout_err), 32'(0));
      end
      reset = 1'b0;
      cyc(2);
      chk("idle_v", 32'(grant_valid), 32'(0));

      // single frame, 1-cycle latency, 2-cycle gap
      req = 16'h0020;
      exp_q.push_back(5);
      @(negedge clock);
      chk("lat1", 32'(grant_valid), 32'(1));
      cyc(11);
      chk("hold5", 32'(grant), 32'h0020);
      exp_q.push_back(5);
      finish_frame(5);
      @(negedge clock);
      chk("gap2", 32'(grant_valid), 32'(0));
      @(negedge clock);
      chk("regrant", 32'(grant_valid), 32'(1));
      req = '0;
      finish_frame(5);
      cyc(2);

      // round robin, all requesting
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      exp_cnt = 0;
      chk("rst2_pkt", 32'(pkt_count), 32'(0));
      req = 16'hFFFF;
      for (int k = 0; k < 17; k++) exp_q.push_back(k % 16);
      for (int k = 0; k < 17; k++) begin
         grant_wait(4);
         cyc(2);
         finish_frame(k % 16);
      end
      req = 16'h8001;
      exp_q.push_back(15);
      exp_q.push_back(0);
      grant_wait(4);
      finish_frame(15);
      grant_wait(4);
      finish_frame(0);
      req = '0;
      cyc(2);

      // timeout release
      req = 16'h0008;
      exp_q.push_back(3);
      grant_wait(4);
      cyc(TIMEOUT - 1);
      chk("tmo_hold", 32'(grant_valid), 32'(1));
      chk("tmo_pre", 32'(timeout_err), 32'(0));
      @(negedge clock);
      chk("tmo_rel", 32'(grant_valid), 32'(0));
      chk("tmo_err", 32'(timeout_err), 32'(1));
      chk("tmo_pkt", 32'(pkt_count), 32'(exp_cnt));
      req = 16'h0018;
      exp_q.push_back(4);
      @(negedge clock);
      chk("tmo_1cyc", 32'(timeout_err), 32'(0));
      grant_wait(4);
      finish_frame(4);

      // done on the last timer cycle wins
      req = 16'h0008;
      exp_q.push_back(3);
      grant_wait(4);
      cyc(TIMEOUT - 1);
      finish_frame(3);
      @(negedge clock);
      chk("dwin_terr", 32'(timeout_err), 32'(0));
      req = '0;
      cyc(1);

      // foreign done and dropped req ignored
      req = 16'h0004;
      exp_q.push_back(2);
      grant_wait(4);
      done = 16'h0080;
      req  = '0;
      @(negedge clock);
      done = '0;
      cyc(3);
      chk("ign_g", 32'(grant), 32'h0004);
      finish_frame(2);
      cyc(2);

      // enable low finishes frame then blocks
      req = 16'h0200;
      exp_q.push_back(9);
      grant_wait(4);
      enable = 1'b0;
      req = 16'hFFFF;
      cyc(3);
      finish_frame(9);
      cyc(10);
      chk("en_block", 32'(grant_valid), 32'(0));
      exp_q.push_back(10);
      enable = 1'b1;
      grant_wait(4);
      finish_frame(10);
      req = '0;
      cyc(2);

      // reset mid-frame
      req = 16'h0001;
      exp_q.push_back(0);
      grant_wait(4);
      cyc(2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_cnt = 0;
      chk("mrst_g", 32'(grant), 32'(0));
      chk("mrst_terr", 32'(timeout_err), 32'(0));
      chk("mrst_pkt", 32'(pkt_count), 32'(0));
      req = 16'hFFFF;
      exp_q.push_back(0);
      grant_wait(4);
      finish_frame(0);
      req = '0;
      cyc(3);
      chk("sb_left", 32'(exp_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
